// File: rtl/spi_bus_slave_pkg.sv
// Shared definitions for the SPI slave front-end: FSM state encoding and
// the default synchronizer depth used by the slave, register bank and bench.
package spi_bus_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_bus_slave_if.sv
// Internal register bus between the SPI slave and the register instances.
// The slave drives address/data/strobes; the register side returns the
// readback byte that is shifted out on MISO.
interface spi_bus_slave_if;
  logic [7:0] addr;
  logic [7:0] data;
  logic       first;
  logic       strobe;
  logic [7:0] rd_data;
  logic       rd_stb;

  modport slave (
    output addr, data, first, strobe, rd_stb,
    input  rd_data
  );

  modport master (
    input  addr, data, first, strobe, rd_stb,
    output rd_data
  );
endinterface

// File: rtl/spi_bus_slave_pin_sync.sv
// N-flop synchronizer for one asynchronous pin with registered rise/fall
// pulses. The chain resets to 0 so a pin already low when reset releases
// produces no edge (a chip select held low is not mistaken for a new fall).
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              last_q;

  // Shift the pin through the chain and register one-cycle edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain  <= '0;
      last_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      chain  <= {chain[STAGES-2:0], pin};
      last_q <= chain[STAGES-1];
      rise   <= chain[STAGES-1] & ~last_q;
      fall   <= ~chain[STAGES-1] & last_q;
    end
  end

endmodule

// File: rtl/spi_bus_slave.sv
// SPI mode-0 slave front-end: synchronizes the pins into clk, assembles
// MSB-first bytes, tags the first byte as address, strobes each following
// data byte onto the register bus and shifts a readback byte out on MISO.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | CS_n high (or after reset); SCK edges ignored
// ADDR    | shifting in the address byte
// DATA    | shifting in data bytes, one strobe per completed byte
module spi_bus_slave
  import spi_bus_slave_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           spi_sck,
  input  logic           spi_cs_n,
  input  logic           spi_mosi,
  output logic           spi_miso,
  output logic           spi_miso_oe,
  spi_bus_slave_if.slave bus
);

  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;

  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_q;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] rx_next;
  logic [7:0] tx_sh;
  logic       first_pending;
  logic       skip_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (spi_sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (spi_cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // MOSI gets the same depth plus one flop so it lines up with the
  // registered SCK/CS_n edge pulses; pin order is preserved across all three.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync <= '0;
      mosi_q    <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      mosi_q    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  assign rx_next  = {rx_sh, mosi_q};
  assign spi_miso = tx_sh[7];

  // Transaction FSM, RX assembly, bus outputs and TX shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= 3'd0;
      rx_sh         <= 7'd0;
      tx_sh         <= 8'd0;
      first_pending <= 1'b0;
      skip_fall     <= 1'b0;
      spi_miso_oe   <= 1'b0;
      bus.addr      <= 8'd0;
      bus.data      <= 8'd0;
      bus.first     <= 1'b0;
      bus.strobe    <= 1'b0;
      bus.rd_stb    <= 1'b0;
    end else begin
      bus.strobe <= 1'b0;
      bus.first  <= 1'b0;
      bus.rd_stb <= 1'b0;

      // rd_data is captured at the end of the rd_stb cycle. The falling edge
      // right after a byte completion is consumed without shifting so the
      // freshly loaded MSB is presented for the next rising edge.
      if (bus.rd_stb) begin
        tx_sh <= bus.rd_data;
      end else if (sck_fall && state != ST_IDLE && !skip_fall) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end
      if (sck_fall) begin
        skip_fall <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state       <= ST_ADDR;
            bit_cnt     <= 3'd0;
            rx_sh       <= 7'd0;
            skip_fall   <= 1'b0;
            spi_miso_oe <= 1'b1;
            bus.rd_stb  <= 1'b1;
          end
        end

        ST_ADDR, ST_DATA: begin
          if (sck_rise) begin
            rx_sh   <= rx_next[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bus.rd_stb <= 1'b1;
              skip_fall  <= 1'b1;
              if (state == ST_ADDR) begin
                bus.addr      <= rx_next;
                first_pending <= 1'b1;
                state         <= ST_DATA;
              end else begin
                bus.data      <= rx_next;
                bus.strobe    <= 1'b1;
                bus.first     <= first_pending;
                first_pending <= 1'b0;
              end
            end
          end
          // A CS_n rise in the same cycle as the 8th bit still completes the
          // byte above; any partial byte is simply dropped here.
          if (cs_rise) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            spi_miso_oe <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_slave.sv
// Bench for spi_bus_slave: a bit-banged SPI master drives transactions,
// expected bus strobes go into a queue checked by an independent monitor,
// and MISO is compared against the readback bytes handed out on rd_stb.
module tb_spi_bus_slave;
  import spi_bus_slave_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic spi_miso_oe;

  spi_bus_slave_if bus ();

  spi_bus_slave #(.SYNC_STAGES(SYNC_STAGES_DEF)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       first;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   strobe_cnt = 0;

  logic [7:0] rd_vals[256];
  int         rd_idx = 0;
  bit         rd_adv = 0;
  int         load_cnt = 0;
  logic [7:0] model_addr = 8'd0;

  assign bus.rd_data = rd_vals[rd_idx & 255];

  // stimulus parameters for run_xfer
  logic [7:0] xb[32];
  int nb, extra, H, phase;
  bit cs_last, chk_miso;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: hands out the next readback byte after each capture and checks
  // every strobe against the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_adv) begin
        rd_idx++;
        rd_adv = 0;
      end
      if (bus.rd_stb) rd_adv = 1;
      if (bus.strobe) begin
        strobe_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe addr=%0h data=%0h first=%0b", bus.addr, bus.data, bus.first);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.addr, bus.data, bus.first} !== mon_e) begin
            fails++;
            $display("FAIL strobe_bus actual addr=%0h data=%0h first=%0b expected addr=%0h data=%0h first=%0b",
                     bus.addr, bus.data, bus.first, mon_e.addr, mon_e.data, mon_e.first);
          end
        end
      end else begin
        tests++;
        if (bus.first !== 1'b0) begin
          fails++;
          $display("FAIL first_idle actual=%0b expected=0", bus.first);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #(phase);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe"},     spi_miso_oe, 0);
    check({tag, "_miso"},   spi_miso,    0);
    check({tag, "_addr"},   bus.addr,    0);
    check({tag, "_data"},   bus.data,    0);
    check({tag, "_first"},  bus.first,   0);
    check({tag, "_strobe"}, bus.strobe,  0);
    check({tag, "_rd_stb"}, bus.rd_stb,  0);
  endtask

  // One CS_n-framed transaction: nb whole bytes (first = address), then
  // `extra` partial bits. Expected strobes and readback bytes come from the
  // byte list and the count of loads so far.
  task automatic run_xfer();
    int base;
    logic b_before, b_after;
    bit sim;
    base = load_cnt;
    tick(1);
    spi_cs_n = 1'b0;
    tick(8);
    check("oe_active", spi_miso_oe, 1);
    for (int j = 0; j < nb; j++) begin
      if (j >= 1) exp_q.push_back({xb[0], xb[j], (j == 1)});
      for (int i = 7; i >= 0; i--) begin
        spi_mosi = xb[j][i];
        tick(H);
        b_before = spi_miso;
        sim = cs_last && (j == nb - 1) && (i == 0) && (extra == 0);
        spi_sck = 1'b1;
        if (sim) spi_cs_n = 1'b1;
        tick(H / 2);
        b_after = spi_miso;
        tick(H - H / 2);
        spi_sck = 1'b0;
        if (chk_miso) begin
          check("miso_setup", b_before, rd_vals[(base + j) & 255][i]);
          check("miso_hold",  b_after,  rd_vals[(base + j) & 255][i]);
        end
      end
    end
    for (int i = 0; i < extra; i++) begin
      spi_mosi = 1'($urandom);
      tick(H);
      spi_sck = 1'b1;
      tick(H);
      spi_sck = 1'b0;
    end
    if (spi_cs_n == 1'b0) begin
      tick(H);
      spi_cs_n = 1'b1;
    end
    tick(12);
    if (nb > 0) model_addr = xb[0];
    load_cnt += 1 + nb;
    check("strobes_drained", exp_q.size(), 0);
    check("addr_hold", bus.addr, model_addr);
    check("rd_stb_count", rd_idx, load_cnt);
    check("oe_released", spi_miso_oe, 0);
  endtask

  initial begin
    int s0;
    for (int i = 0; i < 256; i++) rd_vals[i] = 8'($urandom);
    phase = 2; H = 4; chk_miso = 0; cs_last = 0; extra = 0;

    tick(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(4);

    // single-byte write
    nb = 2; xb[0] = 8'h12; xb[1] = 8'hA5; H = 4; run_xfer();

    // multi-byte write
    nb = 4; xb[0] = 8'h30; xb[1] = 8'h01; xb[2] = 8'h02; xb[3] = 8'h03; run_xfer();

    // partial byte, then a fresh transaction must still flag first
    nb = 1; xb[0] = 8'h40; extra = 5; run_xfer();
    extra = 0;
    nb = 3; xb[0] = 8'h41; xb[1] = 8'h77; xb[2] = 8'h88; run_xfer();

    // readback
    rd_vals[load_cnt & 255] = 8'hC3; rd_vals[(load_cnt + 1) & 255] = 8'h5A;
    nb = 2; xb[0] = 8'h55; xb[1] = 8'h99; H = 6; chk_miso = 1; run_xfer();
    chk_miso = 0;

    // CS_n rises together with the 8th SCK edge: byte still strobed
    nb = 3; xb[0] = 8'h6C; xb[1] = 8'hE1; xb[2] = 8'h3F; H = 3; cs_last = 1; run_xfer();
    cs_last = 0;

    // reset after 3 address bits, then SCK activity with CS_n still low
    s0 = strobe_cnt;
    H = 3; tick(1);
    spi_cs_n = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'($urandom); tick(H); spi_sck = 1'b1; tick(H); spi_sck = 1'b0;
    end
    rst = 1'b1;
    tick(2);
    check_reset_outputs("abort");
    rst = 1'b0;
    model_addr = 8'd0;
    load_cnt += 1;
    for (int i = 0; i < 16; i++) begin
      spi_mosi = 1'($urandom); tick(2); spi_sck = 1'b1; tick(2); spi_sck = 1'b0;
    end
    tick(2);
    spi_cs_n = 1'b1;
    tick(12);
    check("abort_no_strobe", strobe_cnt - s0, 0);
    check("abort_addr", bus.addr, 0);
    check("abort_rd_stb_count", rd_idx, load_cnt);
    check("abort_oe", spi_miso_oe, 0);

    // speed limit: SCK = clk/4, random phase, 16 bytes
    s0 = strobe_cnt;
    H = 2; phase = $urandom_range(1, 8); nb = 16;
    for (int j = 0; j < 16; j++) xb[j] = 8'($urandom);
    run_xfer();
    check("speed_strobe_count", strobe_cnt - s0, 15);

    // random transactions
    for (int t = 0; t < 10; t++) begin
      nb = $urandom_range(1, 5);
      for (int j = 0; j < nb; j++) xb[j] = 8'($urandom);
      extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      cs_last = (extra == 0) && ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0: H = 2;
        1: H = 3;
        default: H = 6;
      endcase
      chk_miso = (H >= 6);
      phase = $urandom_range(1, 8);
      run_xfer();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
